// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared constants, blitter state encoding and ROM select codes.
package bomberman_pkg;
    localparam int SPRITE_W = 16;
    localparam int SPRITE_H = 16;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int ROM_AW   = 12;
    localparam logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(5);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    typedef enum logic [1:0] {MEM_TITLE, MEM_STAGE, MEM_WIN, MEM_SPRITES} mem_sel_e;
endpackage

// File: rtl/sprite_blitter_pixel_scan_counter.sv
// pixel_scan_counter: raster x/y counter over a W x H sprite; wraps to (0,0) after last.
module pixel_scan_counter #(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic                 clock_i,
    input  logic                 resetn_i,
    input  logic                 en_i,
    output logic [$clog2(W)-1:0] x_o,
    output logic [$clog2(H)-1:0] y_o,
    output logic                 last_o
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    // Power-of-2 dimensions let both counters wrap naturally.
    assign x_d = en_i ? x_q + 1'b1 : x_q;
    assign y_d = (en_i && x_q == XW'(W - 1)) ? y_q + 1'b1 : y_q;
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = x_q == XW'(W - 1) && y_q == YW'(H - 1);
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one SPRITE_W x SPRITE_H ROM image into the frame buffer, one pixel per clock.
// Define SPRITE_BLIT_TRANSPARENCY_EN to skip pixels whose colour equals KEY_COLOUR.
module sprite_blitter
    import bomberman_pkg::*;
(
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                start_i,
    input  logic [1:0]          mem_sel_i,
    input  logic [ROM_AW-1:0]   src_base_i,
    input  logic [8:0]          dst_x_i,
    input  logic [7:0]          dst_y_i,
    output logic [1:0]          rom_sel_o,
    output logic [ROM_AW-1:0]   rom_addr_o,
    input  logic [COLOUR_W-1:0] rom_data_i,
    output logic [8:0]          fb_x_o,
    output logic [7:0]          fb_y_o,
    output logic [COLOUR_W-1:0] fb_colour_o,
    output logic                fb_we_o,
    output logic                busy_o,
    output logic                finished_o
);
    localparam int XW = $clog2(SPRITE_W);
    localparam int YW = $clog2(SPRITE_H);
    state_e                state_q, state_d;
    logic                  drain_q, drain_d;
    logic [1:0]            sel_q;
    logic [ROM_AW-1:0]     base_q;
    logic [8:0]            dx_q;
    logic [7:0]            dy_q;
    logic [XW-1:0]         sx;
    logic [YW-1:0]         sy;
    logic                  last, accept, we_d;
    logic                  v1_q;
    logic [9:0]            x1_q;
    logic [8:0]            y1_q;
    logic                  fb_we_q;
    logic [8:0]            fb_x_q;
    logic [7:0]            fb_y_q;
    logic [COLOUR_W-1:0]   col_q;

    pixel_scan_counter #(.W(SPRITE_W), .H(SPRITE_H)) u_scan (
        .clock_i (clock_i),
        .resetn_i(resetn_i),
        .en_i    (state_q == RUN),
        .x_o     (sx),
        .y_o     (sy),
        .last_o  (last)
    );

    assign accept = state_q == IDLE && start_i;

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        unique case (state_q)
            IDLE:    state_d = start_i ? RUN : IDLE;
            RUN:     state_d = last ? DRAIN : RUN;
            DRAIN: begin
                drain_d = ~drain_q;
                state_d = drain_q ? DONE : DRAIN;
            end
            DONE:    state_d = IDLE;
        endcase
    end

    // Coordinate sums are one bit wider than the ports so off-screen pixels are detectable.
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
    assign we_d = v1_q && x1_q < 10'(SCREEN_W) && y1_q < 9'(SCREEN_H) && rom_data_i != KEY_COLOUR;
`else
    assign we_d = v1_q && x1_q < 10'(SCREEN_W) && y1_q < 9'(SCREEN_H);
`endif

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
            sel_q   <= '0;
            base_q  <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            v1_q    <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            fb_we_q <= 1'b0;
            fb_x_q  <= '0;
            fb_y_q  <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (accept) begin
                sel_q  <= mem_sel_i;
                base_q <= src_base_i;
                dx_q   <= dst_x_i;
                dy_q   <= dst_y_i;
            end
            v1_q    <= state_q == RUN;
            x1_q    <= {1'b0, dx_q} + 10'(sx);
            y1_q    <= {1'b0, dy_q} + 9'(sy);
            fb_we_q <= we_d;
            fb_x_q  <= x1_q[8:0];
            fb_y_q  <= y1_q[7:0];
            col_q   <= rom_data_i;
        end
    end

    assign rom_sel_o   = sel_q;
    assign rom_addr_o  = base_q + ROM_AW'({sy, sx});
    assign fb_we_o     = fb_we_q;
    assign fb_x_o      = fb_x_q;
    assign fb_y_o      = fb_y_q;
    assign fb_colour_o = col_q;
    assign busy_o      = state_q != IDLE;
    assign finished_o  = state_q == DONE;
endmodule
